// File: rtl/sseg_updown_counter.sv
// Up/down display counter for the 4-digit seven-segment board display.
// A prescaler advances a WIDTH-bit count every TICK_DIV enabled clocks, with
// wrap or saturate at 0/MAX_VAL and a synchronous clamped load. The count is
// converted to BCD by a sequential shift-add-3 engine and shown on a
// time-multiplexed display with optional leading-zero blanking.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   en       count enable (freezes count and prescaler when low)
//   up       direction: 1 = increment, 0 = decrement
//   load     synchronous load strobe (beats a prescaler step)
//   load_val load value, clamped to MAX_VAL
//   count    current count
//   step     one-cycle pulse on each prescaler-driven count update
//   limit    one-cycle pulse when a step hits a bound
//   bcd      last completed conversion {thousands, hundreds, tens, units}
//   ld       segments, active-low, ld[0]=a .. ld[6]=g
//   an       digit anodes, active-low, an[0] = units
module sseg_updown_counter #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_VAL     = 255,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             limit,
  output logic [15:0]      bcd,
  output logic [6:0]       ld,
  output logic [3:0]       an
);

  localparam int unsigned      PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
  localparam int unsigned      RW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]    REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam int unsigned      IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    ITER_LAST  = IW'(WIDTH - 1);

  // ---------------------------------------------------------------- counter
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] count_nxt;
  logic             at_bound;

  always_comb begin
    at_bound = up ? (count >= MAX_W) : (count == '0);
    if (up)
      count_nxt = at_bound ? ((SAT_MODE != 0) ? MAX_W : '0) : count + WIDTH'(1);
    else
      count_nxt = at_bound ? ((SAT_MODE != 0) ? '0 : MAX_W) : count - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
      step  <= 1'b0;
      limit <= 1'b0;
    end else if (load) begin
      presc <= '0;
      count <= (load_val > MAX_W) ? MAX_W : load_val;
      step  <= 1'b0;
      limit <= 1'b0;
    end else if (en && presc == PRESC_LAST) begin
      presc <= '0;
      count <= count_nxt;
      step  <= 1'b1;
      limit <= at_bound;
    end else begin
      if (en)
        presc <= presc + PW'(1);
      step  <= 1'b0;
      limit <= 1'b0;
    end
  end

  // ---------------------------------------------------------- BCD converter
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  conv_state_t      state_q, state_d;
  logic             snap_en, shift_en, done_en;
  logic [WIDTH-1:0] snap, last_val, sh_bin, sh_bin_nxt;
  logic [15:0]      sh_bcd, sh_bcd_nxt, adj;
  logic [IW-1:0]    iter;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count != last_val) state_d = SHIFT;
      SHIFT:   if (iter == ITER_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_en  = (state_q == IDLE) && (count != last_val);
    shift_en = (state_q == SHIFT);
    done_en  = (state_q == DONE);
  end

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (sh_bcd[4*i +: 4] >= 4'd5) ? 4'(sh_bcd[4*i +: 4] + 4'd3)
                                                 : sh_bcd[4*i +: 4];
    end
    {sh_bcd_nxt, sh_bin_nxt} = {adj[14:0], sh_bin, 1'b0};
  end

  // bcd only loads from the finished shift register, so it never shows a
  // partial result; a count change mid-SHIFT is picked up from IDLE afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap     <= '0;
      last_val <= '0;
      sh_bin   <= '0;
      sh_bcd   <= '0;
      iter     <= '0;
      bcd      <= '0;
    end else begin
      if (snap_en) begin
        snap   <= count;
        sh_bin <= count;
        sh_bcd <= '0;
        iter   <= '0;
      end
      if (shift_en) begin
        sh_bin <= sh_bin_nxt;
        sh_bcd <= sh_bcd_nxt;
        iter   <= iter + IW'(1);
      end
      if (done_en) begin
        bcd      <= sh_bcd;
        last_val <= snap;
      end
    end
  end

  // ------------------------------------------------------------ display mux
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [RW-1:0] refresh;
  logic [1:0]    dig_idx;
  logic [3:0]    sel_nib;
  logic [3:0]    blank;
  logic [6:0]    seg_d;

  always_comb begin
    blank[3] = (BLANK_LZ != 0) && (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
    case (dig_idx)
      2'd0:    sel_nib = bcd[3:0];
      2'd1:    sel_nib = bcd[7:4];
      2'd2:    sel_nib = bcd[11:8];
      default: sel_nib = bcd[15:12];
    endcase
    seg_d = blank[dig_idx] ? 7'b1111111 : seg_decode(sel_nib);
  end

  // an and ld are both registered from the same dig_idx, keeping them aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh <= '0;
      dig_idx <= '0;
      an      <= 4'b1110;
      ld      <= 7'b1000000;
    end else begin
      if (refresh == REF_LAST) begin
        refresh <= '0;
        dig_idx <= dig_idx + 2'd1;
      end else begin
        refresh <= refresh + RW'(1);
      end
      an <= ~(4'b0001 << dig_idx);
      ld <= seg_d;
    end
  end

endmodule

// File: tb/tb_sseg_updown_counter.sv
module tb_sseg_updown_counter;

  logic       clk;
  logic       rst, en, up, load;
  logic [8:0] load_val9;

  logic [7:0]  count, count_s;
  logic [8:0]  count_c;
  logic        step, limit, step_s, limit_s, step_c, limit_c;
  logic [15:0] bcd, bcd_s, bcd_c;
  logic [6:0]  ld, ld_s, ld_c;
  logic [3:0]  an, an_s, an_c;

  int n_chk  = 0;
  int n_fail = 0;

  // Main instance: wrap mode.
  sseg_updown_counter #(
    .TICK_DIV(4), .WIDTH(8), .MAX_VAL(255), .SAT_MODE(0),
    .REFRESH_DIV(2), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val9[7:0]), .count(count), .step(step), .limit(limit),
    .bcd(bcd), .ld(ld), .an(an)
  );

  // Saturating instance.
  sseg_updown_counter #(
    .TICK_DIV(4), .WIDTH(8), .MAX_VAL(255), .SAT_MODE(1),
    .REFRESH_DIV(2), .BLANK_LZ(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val9[7:0]), .count(count_s), .step(step_s), .limit(limit_s),
    .bcd(bcd_s), .ld(ld_s), .an(an_s)
  );

  // 9-bit instance so a load value above MAX_VAL can be presented.
  sseg_updown_counter #(
    .TICK_DIV(4), .WIDTH(9), .MAX_VAL(255), .SAT_MODE(0),
    .REFRESH_DIV(2), .BLANK_LZ(1)
  ) dut_clamp (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val9), .count(count_c), .step(step_c), .limit(limit_c),
    .bcd(bcd_c), .ld(ld_c), .an(an_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, up, load;
    logic [8:0] lv;
    logic [7:0] c;
    logic [8:0] c9;
    logic       s, l;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic u, input logic ldv,
                     input int lv, input int c, input int c9,
                     input logic s, input logic l, input int reps);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = ldv; v.lv = 9'(lv);
    v.c = 8'(c); v.c9 = 9'(c9); v.s = s; v.l = l;
    for (int i = 0; i < reps; i++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] seen;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val9 = '0;

    //   rst en up load  lv    c    c9   s  l  reps
    add(1, 0, 0, 0,   0,    0,   0,   0, 0, 1);  // reset
    add(0, 0, 0, 1, 254,  254, 254,   0, 0, 1);  // load 254
    add(0, 1, 1, 0,   0,  254, 254,   0, 0, 3);  // prescaler 1..3
    add(0, 1, 1, 0,   0,  255, 255,   1, 0, 1);  // step -> 255
    add(0, 1, 1, 0,   0,  255, 255,   0, 0, 3);
    add(0, 1, 1, 0,   0,    0,   0,   1, 1, 1);  // wrap up, limit
    add(0, 1, 1, 0,   0,    0,   0,   0, 0, 1);
    add(0, 1, 0, 0,   0,    0,   0,   0, 0, 2);
    add(0, 1, 0, 0,   0,  255, 255,   1, 1, 1);  // wrap down, limit
    add(0, 1, 0, 1,  20,   20,  20,   0, 0, 1);  // load mid-prescale
    add(0, 1, 0, 0,   0,   20,  20,   0, 0, 3);
    add(0, 1, 0, 1, 300,   44, 255,   0, 0, 1);  // load beats step; clamp
    add(0, 1, 0, 0,   0,   44, 255,   0, 0, 3);  // prescaler restarted
    add(0, 1, 0, 0,   0,   43, 254,   1, 0, 1);
    add(0, 1, 0, 0,   0,   43, 254,   0, 0, 1);  // prescaler = 1
    add(0, 0, 0, 0,   0,   43, 254,   0, 0, 10); // frozen
    add(0, 1, 0, 0,   0,   43, 254,   0, 0, 2);  // resumes at 2, 3
    add(0, 1, 0, 0,   0,   42, 253,   1, 0, 1);
    add(0, 1, 0, 0,   0,   42, 253,   0, 0, 1);
    add(1, 1, 0, 0,   0,    0,   0,   0, 0, 3);  // reset mid-count

    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; up = vq[i].up;
      load = vq[i].load; load_val9 = vq[i].lv;
      tick(1);
      chk($sformatf("v%0d count", i), count, vq[i].c);
      chk($sformatf("v%0d count9", i), count_c, vq[i].c9);
      chk($sformatf("v%0d step", i), step, vq[i].s);
      chk($sformatf("v%0d limit", i), limit, vq[i].l);
    end

    chk("rst bcd", bcd, 16'h0000);
    chk("rst an", an, 4'b1110);
    chk("rst ld", ld, 7'b1000000);
    chk("rst sat count", count_s, 0);

    // Saturate down.
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b1; load_val9 = 9'd1;
    tick(1);
    chk("sat load", count_s, 1);
    load = 1'b0; en = 1'b1;
    tick(3);
    chk("sat pre step", count_s, 1);
    tick(1);
    chk("sat step1 count", count_s, 0);
    chk("sat step1 limit", limit_s, 0);
    chk("wrap step1 count", count, 0);
    tick(3);
    tick(1);
    chk("sat step2 count", count_s, 0);
    chk("sat step2 step", step_s, 1);
    chk("sat step2 limit", limit_s, 1);
    chk("wrap step2 count", count, 255);
    chk("wrap step2 limit", limit, 1);
    tick(1);
    chk("sat limit drop", limit_s, 0);
    tick(2);
    tick(1);
    chk("sat step3 count", count_s, 0);
    chk("sat step3 limit", limit_s, 1);
    chk("wrap step3 count", count, 254);

    // BCD latency and display scan.
    en = 1'b0;
    tick(25);
    chk("bcd settled", bcd, 16'h0254);
    load = 1'b1; load_val9 = 9'd173;
    tick(1);
    load = 1'b0;
    tick(9);
    chk("bcd not yet", bcd, 16'h0254);
    tick(1);
    chk("bcd 173", bcd, 16'h0173);
    tick(1);
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      case (an)
        4'b1110: begin chk("scan d0", ld, 7'b0110000); seen[0] = 1'b1; end
        4'b1101: begin chk("scan d1", ld, 7'b1111000); seen[1] = 1'b1; end
        4'b1011: begin chk("scan d2", ld, 7'b1111001); seen[2] = 1'b1; end
        4'b0111: begin chk("scan d3 blank", ld, 7'b1111111); seen[3] = 1'b1; end
        default: chk("scan an onehot", an, 4'b1110);
      endcase
    end
    chk("scan all digits", seen, 4'hf);

    // Count change during SHIFT: finish 5, then convert 42.
    load = 1'b1; load_val9 = 9'd5;
    tick(1);
    load = 1'b0;
    tick(1);
    load = 1'b1; load_val9 = 9'd42;
    tick(1);
    load = 1'b0;
    tick(7);
    chk("chain before", bcd, 16'h0173);
    tick(1);
    chk("chain first", bcd, 16'h0005);
    tick(9);
    chk("chain hold", bcd, 16'h0005);
    tick(1);
    chk("chain second", bcd, 16'h0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
